grade_avg_classifier: RTL and testbench



---
 rtl/grade_avg_classifier.sv | 122 ++++++++++++
 tb/tb_grade_avg_classifier.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/grade_avg_classifier.sv
// Accumulates NGRADES grades (0-9) from a strobed switch input, averages them,
// classifies the average as A/F/P and drives a seven-segment display.
module grade_avg_classifier #(
    parameter int NGRADES    = 4,
    parameter int PASS_TH    = 7,
    parameter int FINAL_TH   = 4,
    parameter int ALT_PERIOD = 4
) (
    input  logic                             clk_2,
    input  logic                             reset,
    input  logic [3:0]                       grade_in,
    input  logic                             grade_stb,
    input  logic                             clear,
    input  logic [1:0]                       mode,
    output logic [7:0]                       seg,
    output logic [$clog2(NGRADES+1)-1:0]     count,
    output logic [3:0]                       avg,
    output logic                             done,
    output logic                             err
);
    localparam int CW = $clog2(NGRADES + 1);
    localparam int SW = $clog2(9 * NGRADES + 1);
    localparam int SH = $clog2(NGRADES);
    localparam int AW = $clog2(ALT_PERIOD);

    localparam logic [CW-1:0] COUNT_FULL = CW'(NGRADES);
    localparam logic [AW-1:0] ALT_LAST   = AW'(ALT_PERIOD - 1);
    localparam logic [3:0]    PASS_A     = 4'(PASS_TH);
    localparam logic [3:0]    FINAL_F    = 4'(FINAL_TH);

    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_A    = 7'h77;
    localparam logic [6:0] SEG_F    = 7'h71;
    localparam logic [6:0] SEG_P    = 7'h73;

    logic          stb_prev;
    logic          stb_rise;
    logic [3:0]    last;
    logic [SW-1:0] sum;
    logic [AW-1:0] alt_cnt;
    logic          phase;

    function automatic logic [6:0] digit7(input logic [3:0] d);
        case (d)
            4'd0:    digit7 = 7'h3F;
            4'd1:    digit7 = 7'h06;
            4'd2:    digit7 = 7'h5B;
            4'd3:    digit7 = 7'h4F;
            4'd4:    digit7 = 7'h66;
            4'd5:    digit7 = 7'h6D;
            4'd6:    digit7 = 7'h7D;
            4'd7:    digit7 = 7'h07;
            4'd8:    digit7 = 7'h7F;
            4'd9:    digit7 = 7'h67;
            default: digit7 = SEG_DASH;
        endcase
    endfunction

    assign stb_rise = grade_stb & ~stb_prev;
    assign done     = (count == COUNT_FULL);
    assign avg      = 4'(sum >> SH);

    always_ff @(posedge clk_2) begin
        if (reset) begin
            // Starting high means a strobe held through reset is not counted.
            stb_prev <= 1'b1;
            count    <= '0;
            sum      <= '0;
            last     <= '0;
            err      <= 1'b0;
            alt_cnt  <= '0;
            phase    <= 1'b0;
        end else begin
            stb_prev <= grade_stb;
            if (clear) begin
                count   <= '0;
                sum     <= '0;
                last    <= '0;
                err     <= 1'b0;
                alt_cnt <= '0;
                phase   <= 1'b0;
            end else begin
                if (alt_cnt == ALT_LAST) begin
                    alt_cnt <= '0;
                    phase   <= ~phase;
                end else begin
                    alt_cnt <= alt_cnt + AW'(1);
                end
                if (stb_rise) begin
                    if (done || grade_in > 4'd9) begin
                        err <= 1'b1;
                    end else begin
                        last  <= grade_in;
                        sum   <= sum + SW'(grade_in);
                        count <= count + CW'(1);
                    end
                end
            end
        end
    end

    logic [6:0] last_seg, avg_seg, sit_seg, disp;

    always_comb begin
        last_seg = (count == '0) ? SEG_DASH : digit7(last);
        avg_seg  = done ? digit7(avg) : SEG_DASH;
        sit_seg  = SEG_DASH;
        if (done) begin
            if (avg >= PASS_A)       sit_seg = SEG_A;
            else if (avg >= FINAL_F) sit_seg = SEG_F;
            else                     sit_seg = SEG_P;
        end
        case (mode)
            2'b00:   disp = last_seg;
            2'b01:   disp = avg_seg;
            2'b10:   disp = sit_seg;
            default: disp = phase ? sit_seg : avg_seg;
        endcase
        seg = {done, disp};
    end

endmodule

// File: tb/tb_grade_avg_classifier.sv
// Directed plus randomized bench for grade_avg_classifier; a queue of accepted
// grades and a cycles-since-clear counter serve as the reference model.
module tb_grade_avg_classifier;
    localparam int N   = 4;
    localparam int ALT = 4;

    logic       clk_2 = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] grade_in = 4'd0;
    logic       grade_stb = 1'b0;
    logic       clear = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] seg;
    logic [2:0] count;
    logic [3:0] avg;
    logic       done;
    logic       err;

    grade_avg_classifier #(.NGRADES(N), .PASS_TH(7), .FINAL_TH(4), .ALT_PERIOD(ALT)) dut (
        .clk_2(clk_2), .reset(reset), .grade_in(grade_in), .grade_stb(grade_stb),
        .clear(clear), .mode(mode), .seg(seg), .count(count), .avg(avg),
        .done(done), .err(err)
    );

    always #5 clk_2 = ~clk_2;

    int total = 0;
    int bad   = 0;

    // reference model state
    int  grades[$];
    bit  m_err  = 0;
    bit  m_prev = 1;
    int  ncyc   = 0;
    int  dig[10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h67};

    function automatic int m_sum();
        int s = 0;
        foreach (grades[i]) s += grades[i];
        return s;
    endfunction

    function automatic int m_avg();
        return m_sum() / N;
    endfunction

    function automatic int exp_seg(int md);
        bit d = (grades.size() == N);
        int a = m_avg();
        int avg_s = d ? dig[a] : 'h40;
        int sit_s = !d ? 'h40 : (a >= 7) ? 'h77 : (a >= 4) ? 'h71 : 'h73;
        int lo;
        case (md)
            0:       lo = (grades.size() == 0) ? 'h40 : dig[grades[grades.size()-1]];
            1:       lo = avg_s;
            2:       lo = sit_s;
            default: lo = (((ncyc / ALT) % 2) == 1) ? sit_s : avg_s;
        endcase
        return lo | (int'(d) << 7);
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("count", int'(count), grades.size());
        chk("done",  int'(done),  int'(grades.size() == N));
        chk("avg",   int'(avg),   m_avg());
        chk("err",   int'(err),   int'(m_err));
        chk("seg",   int'(seg),   exp_seg(int'(mode)));
    endtask

    // one clock edge: advance model with the inputs present at the edge, then check
    task automatic tick();
        @(posedge clk_2);
        if (reset) begin
            grades.delete(); m_err = 0; m_prev = 1; ncyc = 0;
        end else begin
            if (clear) begin
                grades.delete(); m_err = 0; ncyc = 0;
            end else begin
                ncyc++;
                if (grade_stb && !m_prev) begin
                    if (grades.size() == N || grade_in > 9) m_err = 1;
                    else grades.push_back(int'(grade_in));
                end
            end
            m_prev = grade_stb;
        end
        #1;
        check_all();
    endtask

    task automatic enter(input int g);
        grade_in = 4'(g); grade_stb = 1'b1; tick();
        grade_stb = 1'b0; tick();
    endtask

    task automatic do_clear();
        clear = 1'b1; tick(); clear = 1'b0;
    endtask

    task automatic set_mode(input int md, input int exp);
        mode = 2'(md); #1;
        check_all();
        chk("mode_seg", int'(seg), exp);
    endtask

    initial begin
        // reset with strobe held high
        grade_stb = 1'b1; reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        chk("rst_seg", int'(seg), 'h40);
        tick(); tick();
        chk("stb_held_count", int'(count), 0);
        grade_stb = 1'b0; tick();

        // 7,8,9,6 -> avg 7, A
        mode = 2'b10;
        enter(7); enter(8); enter(9);
        grade_in = 4'd6; grade_stb = 1'b1; tick();
        chk("done_edge", int'(done), 1);
        grade_stb = 1'b0; tick();
        set_mode(2, 'hF7);
        set_mode(1, 'h87);
        set_mode(0, 'hFD);

        // avg 4 -> F, avg 3 -> P
        do_clear(); mode = 2'b10;
        enter(5); enter(4); enter(4); enter(4);
        set_mode(2, 'hF1);
        do_clear();
        enter(3); enter(3); enter(4); enter(5);
        set_mode(2, 'hF3);

        // rejected grade, sticky err, clear
        do_clear(); mode = 2'b00;
        enter(12);
        chk("bad_grade_err", int'(err), 1);
        enter(3); enter(9);
        chk("err_sticky", int'(err), 1);
        do_clear();
        chk("clr_err", int'(err), 0);
        chk("clr_count", int'(count), 0);

        // entry after done, clear with concurrent strobe edge
        enter(1); enter(2); enter(3); enter(4);
        enter(5);
        chk("post_done_count", int'(count), 4);
        chk("post_done_avg", int'(avg), 2);
        chk("post_done_err", int'(err), 1);
        grade_in = 4'd5; grade_stb = 1'b1; clear = 1'b1; tick();
        clear = 1'b0; grade_stb = 1'b0; tick();
        chk("clr_stb_count", int'(count), 0);

        // auto-alternate
        do_clear(); mode = 2'b11;
        enter(7); enter(8); enter(9); enter(6);
        for (int i = 0; i < 2 * ALT + 4; i++) tick();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            grade_in  = 4'($urandom_range(0, 11));
            grade_stb = 1'($urandom_range(0, 1));
            clear     = ($urandom_range(0, 24) == 0);
            reset     = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
